ram_dp_be: RTL and testbench

- Parametrised successor to the single-port data RAM. Generalised in data width, depth and read latency.
- Port A: read/write with byte enables. Port B: independent read-only port for DMA/debug.
- Adds behaviour the old RAM lacks: selectable read-during-write mode, out-of-range address detection, and a post-reset clearing sweep with a ready flag.
- Sits between the core's load/store unit (port A) and auxiliary readers (port B).

---
 rtl/ram_dp_be_if.sv | 31 +++
 rtl/ram_dp_be.sv | 141 ++++++++++++++
 tb/tb_ram_dp_be.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_be_if.sv
// Bus bundle for ram_dp_be: port A read/write, port B read-only, status flags.
interface ram_dp_be_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  a_en;
    logic                  a_we;
    logic [BE_WIDTH-1:0]   a_be;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic [DATA_WIDTH-1:0] a_rdata;
    logic                  a_rvalid;
    logic                  b_en;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_rdata;
    logic                  b_rvalid;
    logic                  ready;
    logic                  addr_err;

    modport master (
        output a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr,
        input  a_rdata, a_rvalid, b_rdata, b_rvalid, ready, addr_err
    );

    modport slave (
        input  a_en, a_we, a_be, a_addr, a_wdata, b_en, b_addr,
        output a_rdata, a_rvalid, b_rdata, b_rvalid, ready, addr_err
    );
endinterface

// File: rtl/ram_dp_be.sv
// Dual-port data RAM: port A read/write with byte enables, port B read-only.
// Clears itself after reset, flags out-of-range requests, 1- or 2-cycle reads.
module ram_dp_be #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MEMORY_SIZE  = 512,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RDW_MODE     = 0
) (
    input logic        clk,
    input logic        rst_n,
    ram_dp_be_if.slave bus
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0]  MEM_LIMIT = (ADDR_WIDTH + 1)'(MEMORY_SIZE);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(MEMORY_SIZE - 1);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic                  r_state;
    logic [IDX_WIDTH-1:0]  r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_mem [MEMORY_SIZE];

    logic                  r_a_v1, r_b_v1, r_err;
    logic [DATA_WIDTH-1:0] r_a_d1, r_b_d1;

    logic                  w_run;
    logic                  w_a_in, w_b_in;
    logic                  w_a_rd, w_a_wr, w_b_rd, w_err;
    logic [IDX_WIDTH-1:0]  w_a_idx, w_b_idx;
    logic [DATA_WIDTH-1:0] w_a_old, w_b_old, w_a_merged, w_a_word, w_b_word;

    // Request decode, byte merge and read-data selection.
    always_comb begin
        w_run   = (r_state == ST_RUN);
        w_a_in  = ({1'b0, bus.a_addr} < MEM_LIMIT);
        w_b_in  = ({1'b0, bus.b_addr} < MEM_LIMIT);
        w_a_idx = bus.a_addr[IDX_WIDTH-1:0];
        w_b_idx = bus.b_addr[IDX_WIDTH-1:0];
        w_a_rd  = w_run && bus.a_en && !bus.a_we;
        w_a_wr  = w_run && bus.a_en && bus.a_we && w_a_in && (|bus.a_be);
        w_b_rd  = w_run && bus.b_en;
        w_err   = w_run && ((bus.a_en && !w_a_in) || (bus.b_en && !w_b_in));
        w_a_old = r_mem[w_a_idx];
        w_b_old = r_mem[w_b_idx];
        w_a_merged = w_a_old;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (bus.a_be[i]) begin
                w_a_merged[8*i +: 8] = bus.a_wdata[8*i +: 8];
            end
        end
        w_a_word = w_a_in ? w_a_old : '0;
        if (!w_b_in) begin
            w_b_word = '0;
        end else if (RDW_MODE == 1 && w_a_wr && bus.a_addr == bus.b_addr) begin
            // Write-first: B sees the word as it will be after this edge.
            w_b_word = w_a_merged;
        end else begin
            w_b_word = w_b_old;
        end
    end

    // Clearing sweep FSM and ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
                r_state <= ST_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    // Storage array: sweep writes zeros, otherwise port A merged writes.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_a_wr) begin
            r_mem[w_a_idx] <= w_a_merged;
        end
    end

    // First read stage and the latency-independent error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_v1 <= 1'b0;
            r_b_v1 <= 1'b0;
            r_a_d1 <= '0;
            r_b_d1 <= '0;
            r_err  <= 1'b0;
        end else begin
            r_a_v1 <= w_a_rd;
            r_b_v1 <= w_b_rd;
            r_err  <= w_err;
            if (w_a_rd) r_a_d1 <= w_a_word;
            if (w_b_rd) r_b_d1 <= w_b_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_a_v2, r_b_v2;
            logic [DATA_WIDTH-1:0] r_a_d2, r_b_d2;

            // Second read stage; data only moves when stage one holds a result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_v2 <= 1'b0;
                    r_b_v2 <= 1'b0;
                    r_a_d2 <= '0;
                    r_b_d2 <= '0;
                end else begin
                    r_a_v2 <= r_a_v1;
                    r_b_v2 <= r_b_v1;
                    if (r_a_v1) r_a_d2 <= r_a_d1;
                    if (r_b_v1) r_b_d2 <= r_b_d1;
                end
            end

            assign bus.a_rvalid = r_a_v2;
            assign bus.a_rdata  = r_a_d2;
            assign bus.b_rvalid = r_b_v2;
            assign bus.b_rdata  = r_b_d2;
        end else begin : g_lat1
            assign bus.a_rvalid = r_a_v1;
            assign bus.a_rdata  = r_a_d1;
            assign bus.b_rvalid = r_b_v1;
            assign bus.b_rdata  = r_b_d1;
        end
    endgenerate

    assign bus.ready    = r_ready;
    assign bus.addr_err = r_err;
endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: a small read-first latency-1 instance and a
// 500-word write-first latency-2 instance.
module tb_ram_dp_be;
    logic clk;
    logic rst0_n, rst1_n;
    int   total, bad, n;

    ram_dp_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) i0 ();
    ram_dp_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) i1 ();

    ram_dp_be #(
        .DATA_WIDTH(16), .MEMORY_SIZE(8), .ADDR_WIDTH(16), .READ_LATENCY(1), .RDW_MODE(0)
    ) u_d0 (.clk(clk), .rst_n(rst0_n), .bus(i0));

    ram_dp_be #(
        .DATA_WIDTH(16), .MEMORY_SIZE(500), .ADDR_WIDTH(16), .READ_LATENCY(2), .RDW_MODE(1)
    ) u_d1 (.clk(clk), .rst_n(rst1_n), .bus(i1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic a0(input logic en, input logic we, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] wd);
        i0.a_en = en; i0.a_we = we; i0.a_be = be; i0.a_addr = addr; i0.a_wdata = wd;
    endtask

    task automatic b0(input logic en, input logic [15:0] addr);
        i0.b_en = en; i0.b_addr = addr;
    endtask

    task automatic a1(input logic en, input logic we, input logic [1:0] be,
                      input logic [15:0] addr, input logic [15:0] wd);
        i1.a_en = en; i1.a_we = we; i1.a_be = be; i1.a_addr = addr; i1.a_wdata = wd;
    endtask

    task automatic b1(input logic en, input logic [15:0] addr);
        i1.b_en = en; i1.b_addr = addr;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        a0(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); b0(1'b0, 16'd0);
        a1(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); b1(1'b0, 16'd0);
        tick; tick;
        chkb("rst_ready", i0.ready, 1'b0);
        chkb("rst_a_rvalid", i0.a_rvalid, 1'b0);
        chkb("rst_b_rvalid", i0.b_rvalid, 1'b0);
        chkb("rst_addr_err", i0.addr_err, 1'b0);
        chkw("rst_a_rdata", i0.a_rdata, 16'h0000);
        chkw("rst_b_rdata", i0.b_rdata, 16'h0000);

        // Release; requests during the sweep must be ignored.
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        a0(1'b1, 1'b0, 2'b11, 16'd0, 16'h0000); b0(1'b1, 16'd9);
        for (int i = 1; i <= 7; i++) begin
            tick;
            chkb("clr_ready", i0.ready, 1'b0);
            chkb("clr_a_rvalid", i0.a_rvalid, 1'b0);
            chkb("clr_b_rvalid", i0.b_rvalid, 1'b0);
            chkb("clr_addr_err", i0.addr_err, 1'b0);
        end
        a0(1'b1, 1'b1, 2'b11, 16'd2, 16'hFFFF);
        tick;
        chkb("clr_done_ready", i0.ready, 1'b1);
        chkb("clr_last_rvalid", i0.b_rvalid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a0(1'b1, 1'b0, 2'b00, 16'(i), 16'h0000); b0(1'b1, 16'(7 - i));
            tick;
            chkb("zero_a_rvalid", i0.a_rvalid, 1'b1);
            chkw("zero_a_rdata", i0.a_rdata, 16'h0000);
            chkb("zero_b_rvalid", i0.b_rvalid, 1'b1);
            chkw("zero_b_rdata", i0.b_rdata, 16'h0000);
        end

        // Byte enables.
        b0(1'b0, 16'd0);
        a0(1'b1, 1'b1, 2'b11, 16'd5, 16'hABCD); tick;
        chkb("wr_no_rvalid", i0.a_rvalid, 1'b0);
        a0(1'b1, 1'b1, 2'b10, 16'd5, 16'h1200); tick;
        a0(1'b1, 1'b1, 2'b00, 16'd5, 16'hFFFF); tick;
        chkb("be0_no_rvalid", i0.a_rvalid, 1'b0);
        a0(1'b1, 1'b0, 2'b00, 16'd5, 16'h0000); tick;
        chkb("be_rvalid", i0.a_rvalid, 1'b1);
        chkw("be_merge", i0.a_rdata, 16'h12CD);
        a0(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); tick;
        chkb("rvalid_drop", i0.a_rvalid, 1'b0);
        chkw("rdata_hold", i0.a_rdata, 16'h12CD);

        // Read-first collision.
        a0(1'b1, 1'b1, 2'b11, 16'd3, 16'h1111); tick;
        a0(1'b1, 1'b1, 2'b11, 16'd3, 16'h5555); b0(1'b1, 16'd3); tick;
        chkw("rdw0_b_old", i0.b_rdata, 16'h1111);
        chkb("rdw0_b_rvalid", i0.b_rvalid, 1'b1);
        chkb("rdw0_a_rvalid", i0.a_rvalid, 1'b0);
        a0(1'b1, 1'b0, 2'b00, 16'd3, 16'h0000); b0(1'b1, 16'd3); tick;
        chkw("dual_a_rdata", i0.a_rdata, 16'h5555);
        chkw("dual_b_rdata", i0.b_rdata, 16'h5555);

        // Out of range on the 8-word instance.
        a0(1'b1, 1'b1, 2'b11, 16'd8, 16'hDEAD); b0(1'b0, 16'd0); tick;
        chkb("oor_wr_err", i0.addr_err, 1'b1);
        chkb("oor_wr_rvalid", i0.a_rvalid, 1'b0);
        a0(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); tick;
        chkb("err_pulse_end", i0.addr_err, 1'b0);
        a0(1'b1, 1'b0, 2'b00, 16'd8, 16'h0000); b0(1'b1, 16'd9); tick;
        chkw("oor_a_rdata", i0.a_rdata, 16'h0000);
        chkb("oor_a_rvalid", i0.a_rvalid, 1'b1);
        chkw("oor_b_rdata", i0.b_rdata, 16'h0000);
        chkb("oor_both_err", i0.addr_err, 1'b1);
        a0(1'b1, 1'b0, 2'b00, 16'd0, 16'h0000); b0(1'b0, 16'd0); tick;
        chkw("oor_no_alias", i0.a_rdata, 16'h0000);
        chkb("inrange_no_err", i0.addr_err, 1'b0);

        // Reset in the middle of a read burst.
        a0(1'b1, 1'b0, 2'b00, 16'd5, 16'h0000); tick;
        chkw("burst_rd5", i0.a_rdata, 16'h12CD);
        a0(1'b1, 1'b0, 2'b00, 16'd3, 16'h0000); tick;
        chkw("burst_rd3", i0.a_rdata, 16'h5555);
        #2 rst0_n = 1'b0;
        #1;
        chkw("midrst_a_rdata", i0.a_rdata, 16'h0000);
        chkb("midrst_a_rvalid", i0.a_rvalid, 1'b0);
        chkb("midrst_ready", i0.ready, 1'b0);
        a0(1'b1, 1'b0, 2'b00, 16'd5, 16'h0000);
        tick;
        rst0_n = 1'b1;
        n = 0;
        while (!i0.ready && n < 20) begin
            tick;
            n++;
        end
        chkw("resweep_len", 16'(n), 16'd8);
        tick;
        chkb("post_rst_rvalid", i0.a_rvalid, 1'b1);
        chkw("post_rst_word", i0.a_rdata, 16'h0000);
        a0(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000);

        // 500-word, latency-2, write-first instance.
        n = 0;
        while (!i1.ready && n < 600) begin
            tick;
            n++;
        end
        chkb("d1_ready", i1.ready, 1'b1);
        a1(1'b1, 1'b1, 2'b11, 16'd1, 16'h0011); tick;
        a1(1'b1, 1'b1, 2'b11, 16'd2, 16'h0022); tick;
        a1(1'b1, 1'b1, 2'b11, 16'd3, 16'h0033); tick;
        a1(1'b1, 1'b0, 2'b00, 16'd1, 16'h0000); tick;
        chkb("l2_wait", i1.a_rvalid, 1'b0);
        a1(1'b1, 1'b0, 2'b00, 16'd2, 16'h0000); tick;
        chkb("l2_v1", i1.a_rvalid, 1'b1);
        chkw("l2_d1", i1.a_rdata, 16'h0011);
        a1(1'b1, 1'b0, 2'b00, 16'd3, 16'h0000); tick;
        chkb("l2_v2", i1.a_rvalid, 1'b1);
        chkw("l2_d2", i1.a_rdata, 16'h0022);
        a1(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); tick;
        chkb("l2_v3", i1.a_rvalid, 1'b1);
        chkw("l2_d3", i1.a_rdata, 16'h0033);
        tick;
        chkb("l2_drop", i1.a_rvalid, 1'b0);
        chkw("l2_hold", i1.a_rdata, 16'h0033);

        // Write-first collision, full word then low byte only.
        a1(1'b1, 1'b1, 2'b11, 16'd3, 16'h1111); tick;
        a1(1'b1, 1'b1, 2'b11, 16'd3, 16'h5555); b1(1'b1, 16'd3); tick;
        chkb("rdw1_wait", i1.b_rvalid, 1'b0);
        a1(1'b1, 1'b1, 2'b01, 16'd3, 16'hAAAA); b1(1'b1, 16'd3); tick;
        chkb("rdw1_rvalid", i1.b_rvalid, 1'b1);
        chkw("rdw1_full", i1.b_rdata, 16'h5555);
        a1(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); b1(1'b0, 16'd0); tick;
        chkw("rdw1_be", i1.b_rdata, 16'h55AA);
        tick;
        chkb("rdw1_drop", i1.b_rvalid, 1'b0);

        // Range boundary at 500.
        a1(1'b1, 1'b1, 2'b11, 16'd499, 16'hBEEF); tick;
        chkb("last_word_no_err", i1.addr_err, 1'b0);
        a1(1'b1, 1'b1, 2'b11, 16'd500, 16'hFFFF); tick;
        chkb("oor500_err", i1.addr_err, 1'b1);
        a1(1'b1, 1'b1, 2'b11, 16'd510, 16'h1234); tick;
        chkb("oor510_err", i1.addr_err, 1'b1);
        a1(1'b1, 1'b0, 2'b00, 16'd499, 16'h0000); tick;
        chkb("rd499_no_err", i1.addr_err, 1'b0);
        a1(1'b1, 1'b0, 2'b00, 16'd600, 16'h0000); b1(1'b1, 16'd700); tick;
        chkb("oor_rd_err_l2", i1.addr_err, 1'b1);
        chkw("rd499_data", i1.a_rdata, 16'hBEEF);
        a1(1'b0, 1'b0, 2'b00, 16'd0, 16'h0000); b1(1'b0, 16'd0); tick;
        chkw("oor600_rdata", i1.a_rdata, 16'h0000);
        chkb("oor600_rvalid", i1.a_rvalid, 1'b1);
        chkw("oor700_rdata", i1.b_rdata, 16'h0000);
        chkb("oor700_rvalid", i1.b_rvalid, 1'b1);
        chkb("oor_err_single", i1.addr_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
